// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle multiply/divide unit owning HI/LO (optional madd/maddu via MD_MADD_EN)
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic        MTWrite,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        valid_op, launch, commit;

  always_comb begin
    valid_op = (MDOp[2] == 1'b0);
`ifdef MD_MADD_EN
    valid_op = valid_op || (MDOp[2:1] == 2'b11);
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    launch     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (Start && valid_op) begin
          launch     = 1'b1;
          state_next = RUN;
          cnt_next   = (MDOp[2:1] == 2'b01) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end
      end
      RUN: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign Busy = (state == RUN);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      op_q <= 3'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
    end else if (launch) begin
      op_q <= MDOp;
      a_q  <= A;
      b_q  <= B;
    end
  end

  // Results are formed from the latched operands; only the commit edge exposes them.
  logic        is_div, div_signed, mul_signed;
  logic [63:0] prod;
  logic [31:0] abs_a, abs_b, divisor, q_mag, r_mag, quot, rem;

  always_comb begin
    is_div     = (op_q[2:1] == 2'b01);
    div_signed = (op_q == 3'd2);
    mul_signed = ~op_q[0];
    prod       = mul_signed ? ({{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q})
                            : ({32'd0, a_q} * {32'd0, b_q});
    abs_a      = (div_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
    abs_b      = (div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
    divisor    = (b_q == 32'd0) ? 32'd1 : abs_b;
    q_mag      = abs_a / divisor;
    r_mag      = abs_a % divisor;
    quot       = (div_signed && (a_q[31] ^ b_q[31])) ? (32'd0 - q_mag) : q_mag;
    rem        = (div_signed && a_q[31]) ? (32'd0 - r_mag) : r_mag;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      HI <= 32'd0;
      LO <= 32'd0;
    end else if (commit) begin
      if (is_div) begin
        if (b_q != 32'd0) begin
          HI <= rem;
          LO <= quot;
        end
      end else begin
`ifdef MD_MADD_EN
        if (op_q[2]) {HI, LO} <= {HI, LO} + prod;
        else         {HI, LO} <= prod;
`else
        {HI, LO} <= prod;
`endif
      end
    end else if (state == IDLE && MTWrite && !Start) begin
      if (MDOp == 3'd4) HI <= A;
      if (MDOp == 3'd5) LO <= A;
    end
  end

endmodule
